// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Brief    : Shared widths, ALU operation codes and multiplier FSM states
//             for the pipeline execute stage.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   localparam int DATA_W    = 32;
   localparam int REG_W     = 5;
   localparam int ALU_W     = 4;
   localparam int MUL_CNT_W = 5;

   // Bit 3 is a don't-care for the first six codes; the shifts and mul use it.
   localparam logic [ALU_W-1:0] ALU_ADD = 4'b0000;
   localparam logic [ALU_W-1:0] ALU_SUB = 4'b0100;
   localparam logic [ALU_W-1:0] ALU_AND = 4'b0001;
   localparam logic [ALU_W-1:0] ALU_OR  = 4'b0101;
   localparam logic [ALU_W-1:0] ALU_XOR = 4'b0010;
   localparam logic [ALU_W-1:0] ALU_LUI = 4'b0110;
   localparam logic [ALU_W-1:0] ALU_SLL = 4'b0011;
   localparam logic [ALU_W-1:0] ALU_SRL = 4'b0111;
   localparam logic [ALU_W-1:0] ALU_SRA = 4'b1111;
   localparam logic [ALU_W-1:0] ALU_MUL = 4'b1011;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } mul_state_t;

   function automatic logic alu_is_mul(input logic [ALU_W-1:0] code);
      return code == ALU_MUL;
   endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_ex_mul.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ex_mul
//  Brief    : Iterative shift-add multiplier (low 32 bits of product), one
//             partial product per cycle. Present only when PIPE_EX_MUL_EN
//             is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`ifdef PIPE_EX_MUL_EN
module pipe_ex_mul
   import pipe_pkg::*;
(
   input  logic              clk,
   input  logic              clrn,
   input  logic              start,
   input  logic              slot_free,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   mul_state_t           r_state;
   logic [MUL_CNT_W-1:0] r_count;
   logic [DATA_W-1:0]    r_acc;
   logic [DATA_W-1:0]    r_mcand;
   logic [DATA_W-1:0]    r_mplier;
   logic [DATA_W-1:0]    w_acc_next;

   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign busy       = (r_state == S_MUL);
   // The last step is folded into the output write so the accumulator
   // simply holds while the output slot is occupied.
   assign done       = busy && (r_count == 5'd31) && slot_free;
   assign product    = w_acc_next;

   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state  <= S_MUL;
                  r_count  <= '0;
                  r_acc    <= '0;
                  r_mcand  <= a;
                  r_mplier <= b;
               end
            end
            S_MUL: begin
               if (r_count != 5'd31) begin
                  r_acc    <= w_acc_next;
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
                  r_count  <= r_count + 5'd1;
               end else if (slot_free) begin
                  r_state <= S_IDLE;
                  r_count <= '0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule : pipe_ex_mul
`endif
`default_nettype wire

// File: rtl/pipe_ex.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ex
//  Brief    : Execute stage: operand select, ALU and EX/MEM output register
//             with valid/ready handshake. PIPE_EX_MUL_EN enables the
//             iterative multiplier for code 1011.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ex
   import pipe_pkg::*;
(
   input  logic              clk,
   input  logic              clrn,
   input  logic              IDvalid,
   output logic              IDstall,
   input  logic              IDwreg,
   input  logic              IDm2reg,
   input  logic              IDwmem,
   input  logic              IDshift,
   input  logic              IDaluimm,
   input  logic [ALU_W-1:0]  IDaluc,
   input  logic [REG_W-1:0]  IDwn,
   input  logic [DATA_W-1:0] IDqa,
   input  logic [DATA_W-1:0] IDqb,
   input  logic [DATA_W-1:0] IDimmeOrSa,
   input  logic              MEMready,
   output logic              EXvalid,
   output logic              EXwreg,
   output logic              EXm2reg,
   output logic              EXwmem,
   output logic [REG_W-1:0]  EXwn,
   output logic [DATA_W-1:0] EXalu,
   output logic [DATA_W-1:0] EXqb
);

   logic              r_ex_valid;
   logic              r_ex_wreg;
   logic              r_ex_m2reg;
   logic              r_ex_wmem;
   logic [REG_W-1:0]  r_ex_wn;
   logic [DATA_W-1:0] r_ex_alu;
   logic [DATA_W-1:0] r_ex_qb;

   logic              w_slot_free;
   logic              w_busy;
   logic              w_accept;
   logic              w_load_id;
   logic [DATA_W-1:0] w_op_a;
   logic [DATA_W-1:0] w_op_b;
   logic [DATA_W-1:0] w_alu;

   assign w_slot_free = !r_ex_valid || MEMready;
   assign w_accept    = IDvalid && !w_busy && w_slot_free;
   assign IDstall     = IDvalid && !w_accept;

   assign w_op_a = IDshift  ? IDimmeOrSa : IDqa;
   assign w_op_b = IDaluimm ? IDimmeOrSa : IDqb;

   always_comb begin
      w_alu = '0;
      case (IDaluc[2:0])
         ALU_ADD[2:0]: w_alu = w_op_a + w_op_b;
         ALU_SUB[2:0]: w_alu = w_op_a - w_op_b;
         ALU_AND[2:0]: w_alu = w_op_a & w_op_b;
         ALU_OR[2:0]:  w_alu = w_op_a | w_op_b;
         ALU_XOR[2:0]: w_alu = w_op_a ^ w_op_b;
         ALU_LUI[2:0]: w_alu = {w_op_b[15:0], 16'h0000};
         // 1011 (mul) yields zero here; with the multiplier built it never loads.
         ALU_SLL[2:0]: w_alu = IDaluc[3] ? '0 : (w_op_b << w_op_a[4:0]);
         ALU_SRL[2:0]: w_alu = IDaluc[3] ? DATA_W'($signed(w_op_b) >>> w_op_a[4:0])
                                         : (w_op_b >> w_op_a[4:0]);
         default:      w_alu = '0;
      endcase
   end

`ifdef PIPE_EX_MUL_EN
   logic              w_mul_start;
   logic              w_mul_done;
   logic [DATA_W-1:0] w_mul_product;
   logic              r_mul_wreg;
   logic              r_mul_m2reg;
   logic              r_mul_wmem;
   logic [REG_W-1:0]  r_mul_wn;
   logic [DATA_W-1:0] r_mul_qb;

   assign w_mul_start = w_accept && alu_is_mul(IDaluc);
   assign w_load_id   = w_accept && !alu_is_mul(IDaluc);

   pipe_ex_mul u_mul (
      .clk       (clk),
      .clrn      (clrn),
      .start     (w_mul_start),
      .slot_free (w_slot_free),
      .a         (w_op_a),
      .b         (w_op_b),
      .busy      (w_busy),
      .done      (w_mul_done),
      .product   (w_mul_product)
   );

   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         r_mul_wreg  <= 1'b0;
         r_mul_m2reg <= 1'b0;
         r_mul_wmem  <= 1'b0;
         r_mul_wn    <= '0;
         r_mul_qb    <= '0;
      end else if (w_mul_start) begin
         r_mul_wreg  <= IDwreg;
         r_mul_m2reg <= IDm2reg;
         r_mul_wmem  <= IDwmem;
         r_mul_wn    <= IDwn;
         r_mul_qb    <= IDqb;
      end
   end
`else
   assign w_busy    = 1'b0;
   assign w_load_id = w_accept;
`endif

   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         r_ex_valid <= 1'b0;
         r_ex_wreg  <= 1'b0;
         r_ex_m2reg <= 1'b0;
         r_ex_wmem  <= 1'b0;
         r_ex_wn    <= '0;
         r_ex_alu   <= '0;
         r_ex_qb    <= '0;
      end else if (w_load_id) begin
         r_ex_valid <= 1'b1;
         r_ex_wreg  <= IDwreg;
         r_ex_m2reg <= IDm2reg;
         r_ex_wmem  <= IDwmem;
         r_ex_wn    <= IDwn;
         r_ex_alu   <= w_alu;
         r_ex_qb    <= IDqb;
`ifdef PIPE_EX_MUL_EN
      end else if (w_mul_done) begin
         r_ex_valid <= 1'b1;
         r_ex_wreg  <= r_mul_wreg;
         r_ex_m2reg <= r_mul_m2reg;
         r_ex_wmem  <= r_mul_wmem;
         r_ex_wn    <= r_mul_wn;
         r_ex_alu   <= w_mul_product;
         r_ex_qb    <= r_mul_qb;
`endif
      end else if (r_ex_valid && MEMready) begin
         // Drained with nothing new: drop the side-effecting controls.
         r_ex_valid <= 1'b0;
         r_ex_wreg  <= 1'b0;
         r_ex_m2reg <= 1'b0;
         r_ex_wmem  <= 1'b0;
      end
   end

   assign EXvalid = r_ex_valid;
   assign EXwreg  = r_ex_wreg;
   assign EXm2reg = r_ex_m2reg;
   assign EXwmem  = r_ex_wmem;
   assign EXwn    = r_ex_wn;
   assign EXalu   = r_ex_alu;
   assign EXqb    = r_ex_qb;

endmodule : pipe_ex
`default_nettype wire

// File: tb/tb_pipe_ex.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ex
//  Brief    : Self-checking bench for pipe_ex with an expected-result queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ex;

   logic        clk;
   logic        clrn;
   logic        IDvalid;
   logic        IDstall;
   logic        IDwreg;
   logic        IDm2reg;
   logic        IDwmem;
   logic        IDshift;
   logic        IDaluimm;
   logic [3:0]  IDaluc;
   logic [4:0]  IDwn;
   logic [31:0] IDqa;
   logic [31:0] IDqb;
   logic [31:0] IDimmeOrSa;
   logic        MEMready;
   logic        EXvalid;
   logic        EXwreg;
   logic        EXm2reg;
   logic        EXwmem;
   logic [4:0]  EXwn;
   logic [31:0] EXalu;
   logic [31:0] EXqb;

   typedef struct packed {
      logic        wreg;
      logic        m2reg;
      logic        wmem;
      logic [4:0]  wn;
      logic [31:0] alu;
      logic [31:0] qb;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   pipe_ex dut (
      .clk        (clk),
      .clrn       (clrn),
      .IDvalid    (IDvalid),
      .IDstall    (IDstall),
      .IDwreg     (IDwreg),
      .IDm2reg    (IDm2reg),
      .IDwmem     (IDwmem),
      .IDshift    (IDshift),
      .IDaluimm   (IDaluimm),
      .IDaluc     (IDaluc),
      .IDwn       (IDwn),
      .IDqa       (IDqa),
      .IDqb       (IDqb),
      .IDimmeOrSa (IDimmeOrSa),
      .MEMready   (MEMready),
      .EXvalid    (EXvalid),
      .EXwreg     (EXwreg),
      .EXm2reg    (EXm2reg),
      .EXwmem     (EXwmem),
      .EXwn       (EXwn),
      .EXalu      (EXalu),
      .EXqb       (EXqb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference ALU written from the opcode table, independent of the RTL.
   function automatic logic [31:0] model_alu(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [4:0] s;
      s = a[4:0];
      case (c)
         4'b0000, 4'b1000: return a + b;
         4'b0100, 4'b1100: return a - b;
         4'b0001, 4'b1001: return a & b;
         4'b0101, 4'b1101: return a | b;
         4'b0010, 4'b1010: return a ^ b;
         4'b0110, 4'b1110: return b * 32'h0001_0000;
         4'b0011:          return b << s;
         4'b0111:          return b >> s;
         4'b1111:          return (b >> s) | (b[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
`ifdef PIPE_EX_MUL_EN
         4'b1011:          return a * b;
`else
         4'b1011:          return 32'h0;
`endif
         default:          return 32'h0;
      endcase
   endfunction

   function automatic logic [72:0] ex_bus();
      return {EXvalid, EXwreg, EXm2reg, EXwmem, EXwn, EXalu, EXqb};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] c, input logic sh, input logic ai,
                        input logic [4:0] wn, input logic [31:0] qa, input logic [31:0] qb,
                        input logic [31:0] imm, input logic [2:0] ctl);
      exp_t e;
      IDvalid    = 1'b1;
      IDaluc     = c;
      IDshift    = sh;
      IDaluimm   = ai;
      IDwn       = wn;
      IDqa       = qa;
      IDqb       = qb;
      IDimmeOrSa = imm;
      {IDwreg, IDm2reg, IDwmem} = ctl;
      e.wreg  = ctl[2];
      e.m2reg = ctl[1];
      e.wmem  = ctl[0];
      e.wn    = wn;
      e.alu   = model_alu(c, sh ? imm : qa, ai ? imm : qb);
      e.qb    = qb;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      exp_t e;
      step();
      step();
      n_checks++;
      if (ex_bus() !== 73'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0", ex_bus());
      end
      clrn = 1'b0;
      step();
      drive(4'b0000, 1'b0, 1'b0, 5'd17, 32'h10, 32'h20, 32'h0, 3'b111);
      step();
      IDvalid = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if (ex_bus() !== {1'b1, e}) begin
         n_fail++;
         $display("FAIL reset_preload: got %h required %h", ex_bus(), {1'b1, e});
      end
      #2;
      clrn = 1'b1;
      #1;
      n_checks++;
      if ({EXvalid, EXalu, EXwreg} !== 34'h0) begin
         n_fail++;
         $display("FAIL reset_async: got valid=%b alu=%h wreg=%b required 0 0 0",
                  EXvalid, EXalu, EXwreg);
      end
      step();
      clrn = 1'b0;
      step();
      n_checks++;
      if (IDstall !== 1'b0 || EXvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got stall=%b valid=%b required 0 0", IDstall, EXvalid);
      end
   endtask

   task automatic test_add_imm();
      exp_t e;
      MEMready = 1'b1;
      drive(4'b0000, 1'b0, 1'b1, 5'd9, 32'h0000_0005, 32'h0000_1234, 32'hFFFF_FFFD, 3'b100);
      #1;
      n_checks++;
      if (IDstall !== 1'b0) begin
         n_fail++;
         $display("FAIL add_stall: got %b required 0", IDstall);
      end
      step();
      IDvalid = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if (ex_bus() !== {1'b1, e} || EXalu !== 32'h0000_0002) begin
         n_fail++;
         $display("FAIL add_imm: got %h required %h", ex_bus(), {1'b1, e});
      end
      step();
      n_checks++;
      if (EXvalid !== 1'b0 || EXwreg !== 1'b0) begin
         n_fail++;
         $display("FAIL add_drain: got valid=%b wreg=%b required 0 0", EXvalid, EXwreg);
      end
   endtask

   task automatic test_shift();
      exp_t e;
      MEMready = 1'b1;
      drive(4'b1111, 1'b1, 1'b0, 5'd4, 32'hDEAD_BEEF, 32'h8000_0000, 32'd4, 3'b100);
      step();
      e = sb.pop_front();
      n_checks++;
      if (ex_bus() !== {1'b1, e} || EXalu !== 32'hF800_0000) begin
         n_fail++;
         $display("FAIL shift_sra: got %h required %h", ex_bus(), {1'b1, e});
      end
      drive(4'b0111, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h8000_0000, 32'd4, 3'b100);
      step();
      IDvalid = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if (ex_bus() !== {1'b1, e} || EXalu !== 32'h0800_0000) begin
         n_fail++;
         $display("FAIL shift_srl: got %h required %h", ex_bus(), {1'b1, e});
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [3:0] codes [11];
      exp_t e;
      codes = '{4'b0000, 4'b1000, 4'b0100, 4'b1100, 4'b0001, 4'b0101,
                4'b0010, 4'b0110, 4'b0011, 4'b0111, 4'b1111};
      MEMready = 1'b1;
      for (int i = 0; i < 24; i++) begin
         drive(codes[i % 11], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom), $urandom, $urandom, $urandom, 3'($urandom));
         step();
         e = sb.pop_front();
         n_checks++;
         if (ex_bus() !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL b2b_%0d code=%b: got %h required %h", i, IDaluc, ex_bus(), {1'b1, e});
         end
      end
      IDvalid = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      exp_t       e;
      logic [72:0] held;
      int         bad = 0;
      MEMready = 1'b1;
      drive(4'b0010, 1'b0, 1'b0, 5'd12, 32'hA5A5_0F0F, 32'h0FF0_FF00, 32'h0, 3'b011);
      step();
      e = sb.pop_front();
      held = ex_bus();
      n_checks++;
      if (held !== {1'b1, e}) begin
         n_fail++;
         $display("FAIL bp_first: got %h required %h", held, {1'b1, e});
      end
      MEMready = 1'b0;
      drive(4'b0101, 1'b0, 1'b1, 5'd13, 32'h1200_0034, 32'h5555_AAAA, 32'h0000_8800, 3'b101);
      for (int i = 0; i < 5; i++) begin
         #1;
         if (IDstall !== 1'b1) bad++;
         step();
         if (ex_bus() !== held) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL bp_hold: got %0d stall/stability errors required 0", bad);
      end
      IDvalid = 1'b0;
      #1;
      n_checks++;
      if (IDstall !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_idle_stall: got %b required 0", IDstall);
      end
      IDvalid  = 1'b1;
      MEMready = 1'b1;
      #1;
      n_checks++;
      if (IDstall !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release_stall: got %b required 0", IDstall);
      end
      step();
      IDvalid = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if (ex_bus() !== {1'b1, e}) begin
         n_fail++;
         $display("FAIL bp_replace: got %h required %h", ex_bus(), {1'b1, e});
      end
      step();
      n_checks++;
      if (EXvalid !== 1'b0 || EXwmem !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drain: got valid=%b wmem=%b required 0 0", EXvalid, EXwmem);
      end
   endtask

   task automatic test_mul();
      exp_t e;
      MEMready = 1'b1;
      drive(4'b1011, 1'b0, 1'b0, 5'd3, 32'h0001_0003, 32'h0000_0007, 32'h0, 3'b100);
      #1;
      n_checks++;
      if (IDstall !== 1'b0) begin
         n_fail++;
         $display("FAIL mul_accept_stall: got %b required 0", IDstall);
      end
      step();
`ifdef PIPE_EX_MUL_EN
      begin
         int cycles = 0;
         int lows   = 0;
         drive(4'b0000, 1'b0, 1'b0, 5'd6, 32'd100, 32'd23, 32'h0, 3'b100);
         while (EXvalid !== 1'b1 && cycles < 40) begin
            if (IDstall !== 1'b1) lows++;
            step();
            cycles++;
         end
         n_checks++;
         if (cycles != 32 || lows != 0) begin
            n_fail++;
            $display("FAIL mul_latency: got %0d cycles %0d unstalled required 32 0", cycles, lows);
         end
         e = sb.pop_front();
         n_checks++;
         if (ex_bus() !== {1'b1, e} || EXalu !== 32'h0007_0015) begin
            n_fail++;
            $display("FAIL mul_result: got %h required %h", ex_bus(), {1'b1, e});
         end
         step();
         IDvalid = 1'b0;
         e = sb.pop_front();
         n_checks++;
         if (ex_bus() !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL mul_follow: got %h required %h", ex_bus(), {1'b1, e});
         end
         step();
         drive(4'b1011, 1'b0, 1'b0, 5'd7, 32'h0001_0003, 32'h0000_0007, 32'h0, 3'b111);
         step();
         IDvalid = 1'b0;
         repeat (10) step();
         #2;
         clrn = 1'b1;
         #1;
         sb.delete();
         n_checks++;
         if (ex_bus() !== 73'h0) begin
            n_fail++;
            $display("FAIL mul_reset: got %h required 0", ex_bus());
         end
         step();
         clrn = 1'b0;
         step();
         drive(4'b0100, 1'b0, 1'b0, 5'd8, 32'd50, 32'd8, 32'h0, 3'b100);
         #1;
         n_checks++;
         if (IDstall !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_reset_idle: got stall %b required 0", IDstall);
         end
         step();
         IDvalid = 1'b0;
         e = sb.pop_front();
         n_checks++;
         if (ex_bus() !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL mul_reset_next: got %h required %h", ex_bus(), {1'b1, e});
         end
         step();
      end
`else
      IDvalid = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if (ex_bus() !== {1'b1, e} || EXalu !== 32'h0) begin
         n_fail++;
         $display("FAIL mul_off: got %h required %h", ex_bus(), {1'b1, e});
      end
      step();
`endif
   endtask

   initial begin
      clrn       = 1'b1;
      IDvalid    = 1'b0;
      IDwreg     = 1'b0;
      IDm2reg    = 1'b0;
      IDwmem     = 1'b0;
      IDshift    = 1'b0;
      IDaluimm   = 1'b0;
      IDaluc     = 4'h0;
      IDwn       = 5'h0;
      IDqa       = 32'h0;
      IDqb       = 32'h0;
      IDimmeOrSa = 32'h0;
      MEMready   = 1'b1;
      test_reset();
      test_add_imm();
      test_shift();
      test_back_to_back();
      test_backpressure();
      test_mul();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pipe_ex
`default_nettype wire
